// File: rtl/cpu_div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, divide-by-zero
// quotient constant, default width and op-bit positions as decoded in ID.
package cpu_div_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam logic [DIV_DATA_W-1:0] DIV_ZERO_QUO = '1;

  // Bit positions of the divide op-field as produced by the decoder
  localparam int OP_SIGNED_BIT = 0;
  localparam int OP_MOD_BIT    = 1;

endpackage

// File: rtl/div_restore_step.sv
// One combinational radix-2 restoring step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it is non-negative.
module div_restore_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic              i_msb,
  input  logic [DATA_W-1:0] i_dvsr,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_qbit
);

  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_diff;

  // Partial remainder stays below the divisor, so one extra bit holds the sign
  assign w_shift = {i_rem, i_msb};
  assign w_diff  = w_shift - {1'b0, i_dvsr};
  assign o_qbit  = ~w_diff[DATA_W];
  assign o_rem   = o_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];

endmodule

// File: rtl/div_unit_iter.sv
// Multi-cycle restoring divider for DIV.W/DIV.WU/MOD.W/MOD.WU with valid/ready
// handshakes and flush. Define DIV_ZERO_FAST_EN to bypass iteration on a zero divisor.
module div_unit_iter
  import cpu_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_signed,
  input  logic              in_mod,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_div_zero
);

  localparam logic [DATA_W-1:0] ZERO_QUO = {DATA_W{DIV_ZERO_QUO[0]}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);

  div_state_e        r_state;
  div_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dvsr;
  logic [DATA_W-1:0] r_result;
  logic              r_qsign;
  logic              r_rsign;
  logic              r_mod;
  logic              r_zero;
  logic              r_div_zero;

  logic [1:0]        w_op;
  logic              w_accept;
  logic              w_s1;
  logic              w_s2;
  logic              w_src2_zero;
  logic              w_fast_zero;
  logic              w_last;
  logic              w_qbit;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quo_fin;
  logic [DATA_W-1:0] w_rem_fin;
  logic [DATA_W-1:0] w_final;

  function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] f_abs(input logic [DATA_W-1:0] x,
                                              input logic              neg);
    return neg ? f_neg(x) : x;
  endfunction

  assign w_op[OP_SIGNED_BIT] = in_signed;
  assign w_op[OP_MOD_BIT]    = in_mod;

  assign w_accept    = in_valid & in_ready & ~flush;
  assign w_s1        = w_op[OP_SIGNED_BIT] & in_src1[DATA_W-1];
  assign w_s2        = w_op[OP_SIGNED_BIT] & in_src2[DATA_W-1];
  assign w_src2_zero = (in_src2 == '0);
  assign w_last      = (r_state == ST_CALC) && (r_cnt == CNT_LAST);

`ifdef DIV_ZERO_FAST_EN
  assign w_fast_zero = w_src2_zero;
`else
  assign w_fast_zero = 1'b0;
`endif

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_state_nxt = w_fast_zero ? ST_DONE : ST_CALC;
      end
      ST_CALC: if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  // Counter runs 0..DATA_W; the extra count is the sign-correction cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                r_cnt <= '0;
    else if (w_accept)                          r_cnt <= '0;
    else if ((r_state == ST_CALC) && !w_last)   r_cnt <= r_cnt + 1'b1;
  end

  // ---- iteration datapath ----
  div_restore_step #(.DATA_W(DATA_W)) u_step (
    .i_rem  (r_rem),
    .i_msb  (r_quo[DATA_W-1]),
    .i_dvsr (r_dvsr),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rem   <= '0;
      r_quo   <= f_abs(in_src1, w_s1);
      r_dvsr  <= f_abs(in_src2, w_s2);
      r_qsign <= w_s1 ^ w_s2;
      r_rsign <= w_s1;
      r_mod   <= w_op[OP_MOD_BIT];
      r_zero  <= w_src2_zero;
    end else if ((r_state == ST_CALC) && !w_last) begin
      r_rem <= w_rem_nxt;
      r_quo <= {r_quo[DATA_W-2:0], w_qbit};
    end
  end

  // ---- sign correction and result register ----
  // With a zero divisor the core leaves |src1| as remainder, so the signed
  // correction reproduces src1 exactly; only the quotient needs forcing.
  assign w_quo_fin = r_qsign ? f_neg(r_quo) : r_quo;
  assign w_rem_fin = r_rsign ? f_neg(r_rem) : r_rem;
  assign w_final   = r_mod ? w_rem_fin : (r_zero ? ZERO_QUO : w_quo_fin);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_result   <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept && w_fast_zero) begin
      r_result   <= w_op[OP_MOD_BIT] ? in_src1 : ZERO_QUO;
      r_div_zero <= 1'b1;
    end else if (w_last && !flush) begin
      r_result   <= w_final;
      r_div_zero <= r_zero;
    end
  end

  assign out_result   = r_result;
  assign out_div_zero = r_div_zero;

endmodule

// File: tb/tb_div_unit_iter.sv
// Self-checking bench for div_unit_iter: scoreboard of expected results checked
// against DUT output, plus reset, flush, hold and back-to-back scenarios.
module tb_div_unit_iter;

  localparam int DW = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_signed = 1'b0;
  logic          in_mod = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_src1 = '0;
  logic [DW-1:0] in_src2 = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_div_zero;
  logic [DW-1:0] out_result;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [DW-1:0] res;
    logic          dz;
    int            lat;
  } exp_t;
  exp_t sb[$];

  div_unit_iter #(.DATA_W(DW), .CNT_W(6)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_signed    (in_signed),
    .in_mod       (in_mod),
    .in_src1      (in_src1),
    .in_src2      (in_src2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_div_zero (out_div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] model(input logic sg, input logic md,
                                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (b == '0) return md ? a : 32'hFFFF_FFFF;
    if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return md ? 32'h0 : 32'h8000_0000;
      return md ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return md ? a % b : a / b;
  endfunction

  task automatic do_op(input string nm, input logic sg, input logic md,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
    exp_t e;
    exp_t g;
    int   lat;
    logic seen;
    e.res = model(sg, md, a, b);
    e.dz  = (b == '0);
    e.lat = (b == '0) ? ZLAT : 33;
    sb.push_back(e);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s in_ready_before_accept: got %b want 1", nm, in_ready);
    end
    in_valid = 1'b1; in_signed = sg; in_mod = md; in_src1 = a; in_src2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk); lat++; #1;
      seen = out_valid;
    end
    g = sb.pop_front();
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s out_valid_timeout: got 0 after %0d cycles want 1", nm, lat);
    end
    n_cmp++;
    if (out_result !== g.res) begin
      n_err++;
      $display("FAIL %s result: got %h want %h", nm, out_result, g.res);
    end
    n_cmp++;
    if (out_div_zero !== g.dz) begin
      n_err++;
      $display("FAIL %s div_zero: got %b want %b", nm, out_div_zero, g.dz);
    end
    n_cmp++;
    if (lat != g.lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, g.lat);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_result !== g.res || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold_cycle%0d: got res=%h vld=%b rdy=%b want res=%h vld=1 rdy=0",
                 nm, k, out_result, out_valid, in_ready, g.res);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_handshake: got rdy=%b vld=%b want rdy=1 vld=0", nm, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 || out_div_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%b vld=%b res=%h dz=%b want 1 0 0 0",
               in_ready, out_valid, out_result, out_div_zero);
    end
    resetn = 1'b1;
  endtask

  task automatic test_unsigned();
    do_op("u100div7", 1'b0, 1'b0, 32'd100, 32'd7, 0);
    do_op("u100mod7", 1'b0, 1'b1, 32'd100, 32'd7, 0);
  endtask

  task automatic test_signed();
    do_op("s-7div2",  1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("s-7mod2",  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("s7div-2",  1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 0);
    do_op("s7mod-2",  1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    do_op("ovf_div",  1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("ovf_mod",  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("u_big",    1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_div_zero();
    do_op("z_s_div", 1'b1, 1'b0, 32'd5, 32'd0, 0);
    do_op("z_s_mod", 1'b1, 1'b1, 32'd5, 32'd0, 0);
    do_op("z_u_div", 1'b0, 1'b0, 32'd5, 32'd0, 0);
    do_op("z_u_mod", 1'b0, 1'b1, 32'd5, 32'd0, 0);
    do_op("z_s_negmod", 1'b1, 1'b1, 32'hFFFF_FFF3, 32'd0, 0);
  endtask

  task automatic test_flush();
    logic seen;
    @(negedge clk);
    in_valid = 1'b1; in_signed = 1'b0; in_mod = 1'b0; in_src1 = 32'd1000; in_src2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_calc_to_idle: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL flush_no_output: got out_valid=1 want never");
    end
    do_op("after_flush_9div3", 1'b0, 1'b0, 32'd9, 32'd3, 0);
  endtask

  task automatic test_hold_and_flush_priority();
    do_op("hold_1000div10", 1'b0, 1'b0, 32'd1000, 32'd10, 5);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_src1 = 32'd50; in_src2 = 32'd5;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_beats_valid: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = b >> 20;
      do_op("rand", i[0], i[1], a, b, 0);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    in_valid = 1'b1; in_signed = 1'b0; in_mod = 1'b0; in_src1 = 32'd77; in_src2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 || out_div_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midop: got rdy=%b vld=%b res=%h dz=%b want 1 0 0 0",
               in_ready, out_valid, out_result, out_div_zero);
    end
    @(negedge clk);
    resetn = 1'b1;
    do_op("after_reset_77div7", 1'b0, 1'b0, 32'd77, 32'd7, 0);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_flush();
    test_hold_and_flush_priority();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
